// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: registers the steering commands, soft-starts each channel's PWM
// duty and forces a coast interval on every direction reversal.
module motor_pwm_driver #(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned DUTY_MAX    = 200,
    parameter int unsigned RAMP_DIV    = 1000,
    parameter int unsigned DEAD_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] motor_in,
    input  logic [1:0] motor_en,
    output logic [3:0] hbridge_in,
    output logic [1:0] hbridge_en,
    output logic [1:0] ch_busy
);

    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_LAST = PWM_BITS'(DUTY_MAX - 1);

    typedef enum logic [1:0] {StIdle, StRamp, StRun, StDead} state_e;

    logic [3:0]          cmd_dir_q;
    logic [1:0]          cmd_en_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    state_e              state    [2];
    logic [PWM_BITS-1:0] duty     [2];
    logic [1:0]          dir      [2];
    logic [RW-1:0]       ramp_cnt [2];
    logic [DW-1:0]       dead_cnt [2];
    logic [1:0]          req;

    always_comb begin
        req = '0;
        for (int c = 0; c < 2; c++) begin
            req[c] = cmd_en_q[c] &&
                     (cmd_dir_q[2*c +: 2] == 2'b10 || cmd_dir_q[2*c +: 2] == 2'b01);
        end
    end

    // Outputs are assigned alongside each transition so pins follow the state on the same edge.
    // hbridge_en compares the pre-edge counter and duty, so a duty step shows up one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_dir_q  <= '0;
            cmd_en_q   <= '0;
            pwm_cnt    <= '0;
            hbridge_in <= '0;
            hbridge_en <= '0;
            ch_busy    <= '0;
            for (int c = 0; c < 2; c++) begin
                state[c]    <= StIdle;
                duty[c]     <= '0;
                dir[c]      <= '0;
                ramp_cnt[c] <= '0;
                dead_cnt[c] <= '0;
            end
        end else begin
            cmd_dir_q <= motor_in;
            cmd_en_q  <= motor_en;
            pwm_cnt   <= pwm_cnt + 1'b1;
            for (int c = 0; c < 2; c++) begin
                case (state[c])
                    StIdle: begin
                        hbridge_en[c] <= 1'b0;
                        ch_busy[c]    <= 1'b0;
                        duty[c]       <= '0;
                        if (req[c]) begin
                            state[c]            <= StRamp;
                            dir[c]              <= cmd_dir_q[2*c +: 2];
                            ramp_cnt[c]         <= '0;
                            hbridge_in[2*c +: 2] <= cmd_dir_q[2*c +: 2];
                        end else begin
                            hbridge_in[2*c +: 2] <= 2'b00;
                        end
                    end
                    StRamp, StRun: begin
                        if (!req[c]) begin
                            state[c]             <= StIdle;
                            duty[c]              <= '0;
                            hbridge_in[2*c +: 2] <= 2'b00;
                            hbridge_en[c]        <= 1'b0;
                            ch_busy[c]           <= 1'b0;
                        end else if (cmd_dir_q[2*c +: 2] != dir[c]) begin
                            state[c]             <= StDead;
                            duty[c]              <= '0;
                            dead_cnt[c]          <= '0;
                            hbridge_in[2*c +: 2] <= 2'b00;
                            hbridge_en[c]        <= 1'b0;
                            ch_busy[c]           <= 1'b1;
                        end else begin
                            hbridge_in[2*c +: 2] <= dir[c];
                            hbridge_en[c]        <= (pwm_cnt < duty[c]);
                            ch_busy[c]           <= 1'b0;
                            if (state[c] == StRamp) begin
                                if (ramp_cnt[c] == RAMP_LAST) begin
                                    ramp_cnt[c] <= '0;
                                    duty[c]     <= duty[c] + 1'b1;
                                    if (duty[c] == DUTY_LAST) begin
                                        state[c] <= StRun;
                                    end
                                end else begin
                                    ramp_cnt[c] <= ramp_cnt[c] + 1'b1;
                                end
                            end
                        end
                    end
                    StDead: begin
                        hbridge_en[c] <= 1'b0;
                        duty[c]       <= '0;
                        // Command changes and disables are ignored until the count expires.
                        if (dead_cnt[c] == DEAD_LAST) begin
                            ch_busy[c] <= 1'b0;
                            if (req[c]) begin
                                state[c]             <= StRamp;
                                dir[c]               <= cmd_dir_q[2*c +: 2];
                                ramp_cnt[c]          <= '0;
                                hbridge_in[2*c +: 2] <= cmd_dir_q[2*c +: 2];
                            end else begin
                                state[c]             <= StIdle;
                                hbridge_in[2*c +: 2] <= 2'b00;
                            end
                        end else begin
                            dead_cnt[c]          <= dead_cnt[c] + 1'b1;
                            ch_busy[c]           <= 1'b1;
                            hbridge_in[2*c +: 2] <= 2'b00;
                        end
                    end
                    default: state[c] <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: a time-stamped reference model feeds a per-cycle scoreboard,
// plus a few directed window counts for duty, dead-time length and invalid codes.
module tb_motor_pwm_driver;

    localparam int PB = 8;
    localparam int DM = 200;
    localparam int RD = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] motor_in;
    logic [1:0] motor_en;
    logic [3:0] hbridge_in;
    logic [1:0] hbridge_en;
    logic [1:0] ch_busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] pins;
        logic [1:0] en;
        logic [1:0] busy;
    } exp_t;

    exp_t expq[$];

    typedef enum int {MIdle, MDrive, MDead} mode_t;

    motor_pwm_driver #(
        .PWM_BITS   (PB),
        .DUTY_MAX   (DM),
        .RAMP_DIV   (RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .motor_in  (motor_in),
        .motor_en  (motor_en),
        .hbridge_in(hbridge_in),
        .hbridge_en(hbridge_en),
        .ch_busy   (ch_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Duty after edge e for a ramp started at edge t0.
    function automatic int duty_at(input int t0, input int e);
        int k;
        k = (e - t0) / RD;
        return (k > DM) ? DM : k;
    endfunction

    // Reference model: per channel only a mode, the ramp start edge and the dead start edge.
    initial begin : model
        mode_t      mode   [2];
        int         t_ramp [2];
        int         t_dead [2];
        logic [1:0] mdir   [2];
        logic [3:0] cq_in;
        logic [1:0] cq_en;
        logic [1:0] rd;
        int         edge_n;
        int         pwm_n;
        int         pwm_prev;
        int         dprev;
        bit         rq;
        exp_t       x;
        edge_n = 0;
        pwm_n  = 0;
        cq_in  = '0;
        cq_en  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            mode[ch] = MIdle; t_ramp[ch] = 0; t_dead[ch] = 0; mdir[ch] = 2'b00;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            x = '0;
            if (reset) begin
                pwm_n = 0;
                cq_in = '0;
                cq_en = '0;
                for (int ch = 0; ch < 2; ch++) begin
                    mode[ch] = MIdle;
                    mdir[ch] = 2'b00;
                end
            end else begin
                pwm_prev = pwm_n % (1 << PB);
                pwm_n++;
                for (int ch = 0; ch < 2; ch++) begin
                    rd    = cq_in[2*ch +: 2];
                    rq    = cq_en[ch] && (rd == 2'b10 || rd == 2'b01);
                    dprev = (mode[ch] == MDrive) ? duty_at(t_ramp[ch], edge_n - 1) : 0;
                    case (mode[ch])
                        MIdle: if (rq) begin
                            mode[ch] = MDrive; t_ramp[ch] = edge_n; mdir[ch] = rd;
                        end
                        MDrive: begin
                            if (!rq) mode[ch] = MIdle;
                            else if (rd != mdir[ch]) begin
                                mode[ch] = MDead; t_dead[ch] = edge_n;
                            end
                        end
                        default: if (edge_n - t_dead[ch] == DC) begin
                            if (rq) begin
                                mode[ch] = MDrive; t_ramp[ch] = edge_n; mdir[ch] = rd;
                            end else begin
                                mode[ch] = MIdle;
                            end
                        end
                    endcase
                    x.pins[2*ch +: 2] = (mode[ch] == MDrive) ? mdir[ch] : 2'b00;
                    x.en[ch]          = (mode[ch] == MDrive) && (pwm_prev < dprev);
                    x.busy[ch]        = (mode[ch] == MDead);
                end
                cq_in = motor_in;
                cq_en = motor_en;
            end
            expq.push_back(x);
        end
    end

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                check("sb_pins", int'(hbridge_in), int'(x.pins));
                check("sb_en", int'(hbridge_en), int'(x.en));
                check("sb_busy", int'(ch_busy), int'(x.busy));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] pick_dir();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        if (r < 5) return 2'b10;
        return 2'b01;
    endfunction

    initial begin : driver
        int cnt_a, cnt_b;
        reset    = 1'b1;
        motor_in = 4'b0000;
        motor_en = 2'b00;
        cyc(3);
        check("reset_pins", int'(hbridge_in), 0);
        reset = 1'b0;
        cyc(2);

        // Soft start on both channels, then measure one full PWM window in RUN.
        motor_in = 4'b1001;
        motor_en = 2'b11;
        cyc(2);
        check("start_pins", int'(hbridge_in), 4'b1001);
        cyc(810);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            cnt_a += int'(hbridge_en[1]);
            cnt_b += int'(hbridge_en[0]);
        end
        check("run_duty_a", cnt_a, DM);
        check("run_duty_b", cnt_b, DM);

        // Reversal on channel A only.
        motor_in = 4'b0101;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            cnt_a += int'(ch_busy[1]);
            cnt_b += int'(ch_busy[0]);
        end
        check("rev_busy_a", cnt_a, DC);
        check("rev_busy_b", cnt_b, 0);
        check("rev_pins", int'(hbridge_in), 4'b0101);

        // Reset while B runs and A ramps.
        reset = 1'b1;
        cyc(1);
        check("midrun_reset_pins", int'(hbridge_in), 0);
        check("midrun_reset_en", int'(hbridge_en), 0);
        cyc(2);
        reset = 1'b0;
        cyc(40);

        // Disable during ramp, then re-enable.
        motor_en = 2'b00;
        cyc(2);
        check("dis_en", int'(hbridge_en), 0);
        check("dis_pins", int'(hbridge_in), 0);
        cyc(8);
        motor_en = 2'b11;
        cyc(50);

        // Invalid code on channel A.
        motor_in = 4'b1101;
        cnt_a = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (i >= 2) cnt_a += int'(hbridge_in[3:2] != 2'b00) + int'(hbridge_en[1]);
        end
        check("invalid_drive_a", cnt_a, 0);

        // Disable two clocks into a dead interval.
        motor_in = 4'b1001;
        cyc(30);
        motor_in = 4'b0101;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (i == 2) motor_en = 2'b01;
            cnt_a += int'(ch_busy[1]);
        end
        check("dead_dis_busy", cnt_a, DC);
        check("dead_dis_pins_a", int'(hbridge_in[3:2]), 0);
        check("dead_dis_en_a", int'(hbridge_en[1]), 0);

        // Randomized commands with occasional resets; the scoreboard checks every cycle.
        for (int s = 0; s < 60; s++) begin
            motor_in = {pick_dir(), pick_dir()};
            motor_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                cyc($urandom_range(1, 3));
                reset = 1'b0;
            end
            cyc($urandom_range(1, 60));
        end

        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Downstream stage of the rover's line-following motor-command logic. It takes the per-motor direction pairs and enables that the steering block produces and turns them into H-bridge pin drive. For each channel it adds a PWM speed output with a soft-start ramp, and it inserts a forced coast (dead-time) interval on every direction reversal to protect the bridge and gearbox. The outputs connect directly to the two-channel H-bridge IN/EN pins.

## Interface

Parameters:
- PWM_BITS, 8: width of the PWM counter; PWM period is 2^PWM_BITS clocks.
- DUTY_MAX, 200: final duty reached by the ramp (high clocks per period); must be ≤ 2^PWM_BITS−1.
- RAMP_DIV, 1000: clocks per +1 duty step during soft start; ≥1.
- DEAD_CYCLES, 5000: coast clocks inserted on a direction reversal; ≥1.

Ports:
- clk  in  1  system clock; the block uses a single clock.
- reset  in  1  synchronous, active-high reset.
- motor_in  in  4  direction command: [3:2] = channel A, [1:0] = channel B. Per channel: 10 = forward, 01 = reverse, 00/11 = invalid.
- motor_en  in  2  enable command: [1] = channel A, [0] = channel B.
- hbridge_in  out  4  registered bridge direction pins, same bit mapping as motor_in.
- hbridge_en  out  2  registered PWM enable pins, same mapping as motor_en.
- ch_busy  out  2  registered; 1 while the channel is in dead-time.

## Operation

- Both command inputs are registered in one stage (cmd_q) before any use. The inputs come from combinational logic and are treated as asynchronous to the decision point.
- Each channel has an independent FSM with states IDLE, RAMP, RUN and DEAD, plus per-channel registers duty (PWM_BITS), dir (2), ramp_cnt and dead_cnt.
- A channel requests drive ("req") when its cmd_q enable = 1 and its direction is 10 or 01. An invalid direction with enable = 1 is treated as req = 0.
- IDLE:
  - duty = 0, pins coast (00), en = 0.
  - On req: latch dir ← requested direction, clear ramp_cnt, go to RAMP. No dead-time is applied on this transition.
- RAMP:
  - ramp_cnt counts 0..RAMP_DIV−1. At terminal count, duty += 1 and ramp_cnt clears.
  - When duty reaches DUTY_MAX, go to RUN. Duty never exceeds DUTY_MAX.
- RUN: duty is held at DUTY_MAX.
- From RAMP or RUN:
  - req = 0 → IDLE immediately; duty ← 0.
  - req = 1 with a requested direction ≠ dir → DEAD; duty ← 0; pins 00; dead_cnt ← 0.
  - req = 1 with the same direction → no change.
- DEAD:
  - Pins 00, en = 0, ch_busy = 1. dead_cnt counts to DEAD_CYCLES−1.
  - Command changes during DEAD do not restart the count.
  - On exit, the block evaluates the current req. If req = 1: dir ← current requested direction, go to RAMP from duty 0. If req = 0: go to IDLE.
  - Disable cannot shorten DEAD.
- PWM:
  - One free-running counter pwm_cnt (PWM_BITS wide) is shared by both channels. It wraps from 2^PWM_BITS−1 to 0.
  - hbridge_en[ch] = (state is RAMP or RUN) && (pwm_cnt < duty[ch]).
  - In RAMP and RUN, hbridge_in[ch] = dir. In all other states it is 00.
- Reset, applied at any time including mid-DEAD or mid-RAMP, forces:
  - both FSMs to IDLE;
  - duty, dir, ramp_cnt, dead_cnt, pwm_cnt and cmd_q to 0;
  - hbridge_in = 0000, hbridge_en = 00, ch_busy = 00.

## Timing

- Command to pin latency is 2 clocks:
  - edge N: input change captured into cmd_q;
  - edge N+1: FSM transition and output registers update.
- Duty after entering RAMP at edge T: duty = k at edge T + k·RAMP_DIV. RUN is entered at edge T + DUTY_MAX·RAMP_DIV.
- DEAD entered at edge D lasts exactly DEAD_CYCLES clocks. ch_busy is high for edges D..D+DEAD_CYCLES−1. New direction pins appear at edge D+DEAD_CYCLES.
- PWM duty is applied on the next clock after each duty update; there is no per-period sync. hbridge_en goes high for exactly duty clocks of each 2^PWM_BITS window.
- Simultaneous events: a reversal on channel A and a disable on channel B in the same cycle are handled independently. The two channels never interact except through the shared pwm_cnt.

## Test plan

Bench parameters: PWM_BITS=8, DUTY_MAX=200, RAMP_DIV=4, DEAD_CYCLES=8.

- Reset mid-RUN:
  - Stimulus: hold reset high for 3 cycles.
  - Response: outputs hbridge_in=0000, hbridge_en=00 and ch_busy=00 on the first reset edge. Both FSMs are IDLE after release. Outputs stay at 0 until the command is re-sampled.
- Soft start:
  - Stimulus: motor_in=1001, motor_en=11 from IDLE.
  - Response: hbridge_in=1001 two clocks later. Duty increments every 4 clocks and reaches 200 after 800 clocks. In RUN, hbridge_en is high for 200 of every 256 clocks on both channels.
- Reversal:
  - Stimulus: in RUN, motor_in goes 1001→0101.
  - Response: within 2 clocks, hbridge_in[3:2]=00, hbridge_en[1]=0 and ch_busy[1]=1 for 8 clocks. Then hbridge_in[3:2]=01 and the ramp restarts from duty 0. Channel B is unaffected.
- Disable during RAMP:
  - Stimulus: motor_en 11→00.
  - Response: within 2 clocks, hbridge_en=00 and hbridge_in=0000. On re-enable, the ramp starts from duty 0.
- Invalid code:
  - Stimulus: motor_in[3:2]=11 with motor_en[1]=1.
  - Response: channel A is IDLE with coast pins 00 and never drives.
- Disable during DEAD:
  - Stimulus: drop motor_en[1] 2 clocks into DEAD.
  - Response: ch_busy[1] stays high for the full 8 clocks, then the channel goes IDLE with no drive.
